operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode/operand-fetch stage sitting directly downstream of the 32x32 register file in the RV32I core.
- Accepts a fetched instruction with its PC and drives the register file read addresses. It captures rs1/rs2 values, generates the immediate and hands a decoded bundle to execute over a valid/ready handshake.
- Holds a busy-bit scoreboard so no instruction issues while one of its source or destination registers has an outstanding write.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, architectural register count; register index width is log2(NREGS)=5.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  32  instruction PC.
- rf_raddr1  out  5  register file read address 1 = in_instr[19:15]; combinational.
- rf_raddr2  out  5  register file read address 2 = in_instr[24:20]; combinational.
- rf_rdata1  in  32  async read data for rf_raddr1.
- rf_rdata2  in  32  async read data for rf_raddr2.
- wb_en  in  1  writeback writes the register file this cycle.
- wb_addr  in  5  writeback destination.
- wb_data  in  32  writeback value.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  32  registered PC.
- out_rs1_val  out  32  registered rs1 value.
- out_rs2_val  out  32  registered rs2 value.
- out_imm  out  32  registered sign-extended immediate.
- out_rd  out  5  destination register.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_illegal  out  1  opcode not one of the nine RV32I base opcodes.

Behaviour:
- Reset (async, rst_n low): out_valid=0, all out_* data=0, busy[31:0]=0.
  - Reset mid-stall drops the held bundle.
- Latency: 1 cycle. An instruction accepted at posedge N is presented with out_valid=1 after posedge N.
- Source usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, only when rd!=0.
- Hazard = (rs1 used and busy[rs1]) or (rs2 used and busy[rs2]) or (rd written and busy[rd]); the last term is the WAW stall.
  - busy[0] is constantly 0.
- in_ready = !hazard && (!out_valid || out_ready).
  - in_ready depends on in_instr, but never on in_valid.
- Accept = in_valid && in_ready. On accept:
  - Load the out_* registers.
  - Set out_valid.
  - Set busy[rd] if rd is written.
- If out_valid && out_ready with no accept: out_valid clears next cycle.
- Stall: while out_valid && !out_ready, all out_* hold stable.
- Scoreboard:
  - wb_en && wb_addr!=0 clears busy[wb_addr] at posedge.
  - If a set and a clear hit the same index in the same cycle, set wins.
- The register file writes on negedge, so data written in cycle N is readable by the posedge ending cycle N. A cleared busy bit therefore always pairs with fresh rf_rdata.
- Immediates: I, S, B, U and J formats per RV32I.
  - B and J carry bit0=0.
  - OP and illegal instructions give imm=0.
- Illegal opcode: out_illegal=1, passes through normally, never sets busy, uses no sources.

Optional Feature:
- Macro OPFETCH_BYPASS_EN.
- Defined: a source with busy[rs]=1 is not a hazard if wb_en && wb_addr==rs in the same cycle; wb_data is captured in place of rf_rdata. This saves one stall cycle per RAW dependency. WAW hazards are unchanged.
- Undefined: there is no forwarding path, and RAW dependencies stall until the cycle after the busy bit clears.

Decomposition:
- Package opfetch_pkg holds:
  - opcode localparams (OPC_LUI=7'b0110111, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP);
  - typedef enum imm_type_t {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - typedef struct decode bundle.
- One combinational sub-module, imm_gen: instr, imm_type_t in; 32-bit imm out.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1 -> out_valid=1 next cycle; out_imm=5, out_rd=1, busy[1]=1.
- Then add x2,x1,x1 with no writeback -> in_ready=0. wb_en=1, wb_addr=1, wb_data=5 -> busy[1] clears.
  - Without bypass: accept occurs the next cycle with out_rs1_val=out_rs2_val=5.
  - With OPFETCH_BYPASS_EN: accept occurs the same cycle.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0. Release -> the next instruction is accepted; no instruction is lost or duplicated.
- beq x0,x0,-8 (0xFE000CE3) -> out_imm=0xFFFFFFF8, no busy set. jal x0,+2048 -> out_imm=0x00000800, rd=0 sets nothing.
- Instruction word 0x0000007F -> out_illegal=1, in_ready stays 1; a following lw x3,4(x2) is accepted with no stall when x2 is idle.
- Accept addi x5 while wb_en=1, wb_addr=5 in the same cycle -> busy[5]=1 (set wins). Assert rst_n low mid-stall -> out_valid=0, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand_fetch stage.
// Optional feature macro: OPFETCH_BYPASS_EN (writeback-to-operand forwarding).
package opfetch_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RAW   = $clog2(NREGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_t;

  // Decoded bundle handed to execute.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            illegal;
  } decode_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Bus interface for operand_fetch: fetch side, register file side,
// writeback snoop and execute side, plus the scoreboard debug view.
//
// Handshakes (both in_* and out_*): a transfer happens on a posedge where
// valid && ready. A producer holding valid keeps its payload stable until
// the transfer; ready may depend on the payload but never on valid.
interface operand_fetch_if;
  import opfetch_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic [RAW-1:0]  rf_raddr1;
  logic [RAW-1:0]  rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;

  logic            wb_en;
  logic [RAW-1:0]  wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [XLEN-1:0] out_imm;
  logic [RAW-1:0]  out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_illegal;

  logic [NREGS-1:0] dbg_busy;

  // Environment side: fetch, register file, writeback and execute.
  modport master (
    output in_valid, in_instr, in_pc,
    input  in_ready,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    output wb_en, wb_addr, wb_data,
    input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
    input  out_rd, out_opcode, out_funct3, out_funct7, out_illegal,
    output out_ready,
    input  dbg_busy
  );

  // The operand_fetch stage itself.
  modport slave (
    input  in_valid, in_instr, in_pc,
    output in_ready,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    input  wb_en, wb_addr, wb_data,
    output out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
    output out_rd, out_opcode, out_funct3, out_funct7, out_illegal,
    input  out_ready,
    output dbg_busy
  );

endinterface

// File: rtl/operand_fetch_imm_gen.sv
// Combinational RV32I immediate generator (I/S/B/U/J, or zero).
module imm_gen
  import opfetch_pkg::*;
(
  input  logic [31:0]     instr,
  input  imm_type_t       imm_type,
  output logic [XLEN-1:0] imm
);

  // Assemble and sign-extend the immediate for the selected format.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage with busy-bit scoreboard.
// Optional feature macro: OPFETCH_BYPASS_EN forwards the writeback value
// to a source whose busy bit is being cleared in the same cycle.
module operand_fetch
  import opfetch_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);

  logic [6:0]     opcode;
  logic [RAW-1:0] rs1;
  logic [RAW-1:0] rs2;
  logic [RAW-1:0] rd;

  logic      use_rs1;
  logic      use_rs2;
  logic      has_rd;
  logic      writes_rd;
  logic      illegal;
  imm_type_t imm_type;

  logic [XLEN-1:0] imm;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic fwd1;
  logic fwd2;
  logic haz1;
  logic haz2;
  logic haz_rd;
  logic hazard;
  logic accept;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  decode_t bundle_d;
  decode_t bundle_q;
  logic    out_valid_q;

  assign opcode = bus.in_instr[6:0];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign rd     = bus.in_instr[11:7];

  assign bus.rf_raddr1 = rs1;
  assign bus.rf_raddr2 = rs2;

  // Classify the opcode: which sources it reads, whether it writes rd,
  // and which immediate format it carries.
  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    has_rd   = 1'b0;
    illegal  = 1'b0;
    imm_type = IMM_NONE;
    case (opcode)
      OPC_LUI:    begin has_rd = 1'b1; imm_type = IMM_U; end
      OPC_AUIPC:  begin has_rd = 1'b1; imm_type = IMM_U; end
      OPC_JAL:    begin has_rd = 1'b1; imm_type = IMM_J; end
      OPC_JALR:   begin use_rs1 = 1'b1; has_rd = 1'b1; imm_type = IMM_I; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_B; end
      OPC_LOAD:   begin use_rs1 = 1'b1; has_rd = 1'b1; imm_type = IMM_I; end
      OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_S; end
      OPC_OPIMM:  begin use_rs1 = 1'b1; has_rd = 1'b1; imm_type = IMM_I; end
      OPC_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; end
      default:    illegal = 1'b1;
    endcase
  end

  // x0 is never tracked, so writes to it neither stall nor set busy.
  assign writes_rd = has_rd && (rd != '0);

  imm_gen u_imm_gen (
    .instr    (bus.in_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

`ifdef OPFETCH_BYPASS_EN
  assign fwd1 = bus.wb_en && (bus.wb_addr == rs1) && (rs1 != '0);
  assign fwd2 = bus.wb_en && (bus.wb_addr == rs2) && (rs2 != '0);
  assign rs1_val = fwd1 ? bus.wb_data : bus.rf_rdata1;
  assign rs2_val = fwd2 ? bus.wb_data : bus.rf_rdata2;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
  assign rs1_val = bus.rf_rdata1;
  assign rs2_val = bus.rf_rdata2;
`endif

  // busy_q[0] is held at zero by the next-state logic, so reading it is safe.
  assign haz1   = use_rs1 && busy_q[rs1] && !fwd1;
  assign haz2   = use_rs2 && busy_q[rs2] && !fwd2;
  assign haz_rd = writes_rd && busy_q[rd];
  assign hazard = haz1 || haz2 || haz_rd;

  assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Build the bundle that will be registered on accept.
  always_comb begin
    bundle_d         = '0;
    bundle_d.pc      = bus.in_pc;
    bundle_d.rs1_val = rs1_val;
    bundle_d.rs2_val = rs2_val;
    bundle_d.imm     = imm;
    bundle_d.rd      = rd;
    bundle_d.opcode  = opcode;
    bundle_d.funct3  = bus.in_instr[14:12];
    bundle_d.funct7  = bus.in_instr[31:25];
    bundle_d.illegal = illegal;
  end

  // Output register: load on accept, drop valid once execute takes it,
  // otherwise hold everything stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      bundle_q    <= bundle_d;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Scoreboard next state: writeback clears first, issue sets after, so a
  // set and clear to the same index leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en && (bus.wb_addr != '0)) begin
      busy_d[bus.wb_addr] = 1'b0;
    end
    if (accept && writes_rd) begin
      busy_d[rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = bundle_q.pc;
  assign bus.out_rs1_val = bundle_q.rs1_val;
  assign bus.out_rs2_val = bundle_q.rs2_val;
  assign bus.out_imm     = bundle_q.imm;
  assign bus.out_rd      = bundle_q.rd;
  assign bus.out_opcode  = bundle_q.opcode;
  assign bus.out_funct3  = bundle_q.funct3;
  assign bus.out_funct7  = bundle_q.funct7;
  assign bus.out_illegal = bundle_q.illegal;
  assign bus.dbg_busy    = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch with a negedge-write register file model.
module tb_operand_fetch;
  import opfetch_pkg::*;

  logic clk;
  logic rst_n;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run;
  int tests_failed;

  logic [31:0] rf_mem [NREGS];
  logic [31:0] held_pc;

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: asynchronous read, write on negedge.
  assign bus.rf_rdata1 = (bus.rf_raddr1 == '0) ? 32'h0 : rf_mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = (bus.rf_raddr2 == '0) ? 32'h0 : rf_mem[bus.rf_raddr2];

  always @(negedge clk) begin
    if (bus.wb_en && bus.wb_addr != '0) rf_mem[bus.wb_addr] <= bus.wb_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = valid;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    #1;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'h0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'h0;
    bus.out_ready = 1'b1;

    // Reset state.
    step();
    step();
    check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check_eq("rst_out_pc", bus.out_pc, 32'h0);
    check_eq("rst_out_imm", bus.out_imm, 32'h0);
    check_eq("rst_busy", bus.dbg_busy, 32'h0);
    rst_n = 1'b1;
    step();

    // addi x1,x0,5
    drive_in(1'b1, 32'h00500093, 32'h100);
    check_eq("addi_in_ready", {31'b0, bus.in_ready}, 32'h1);
    check_eq("addi_raddr1", {27'b0, bus.rf_raddr1}, 32'h0);
    step();
    check_eq("addi_out_valid", {31'b0, bus.out_valid}, 32'h1);
    check_eq("addi_imm", bus.out_imm, 32'h5);
    check_eq("addi_rd", {27'b0, bus.out_rd}, 32'h1);
    check_eq("addi_opcode", {25'b0, bus.out_opcode}, 32'h13);
    check_eq("addi_pc", bus.out_pc, 32'h100);
    check_eq("addi_busy", bus.dbg_busy, 32'h2);

    // add x2,x1,x1: RAW on x1, resolved by writeback of x1=5.
    drive_in(1'b1, 32'h00108133, 32'h104);
    check_eq("add_raddr1", {27'b0, bus.rf_raddr1}, 32'h1);
    check_eq("add_raddr2", {27'b0, bus.rf_raddr2}, 32'h1);
    check_eq("add_hazard_ready", {31'b0, bus.in_ready}, 32'h0);
    drive_wb(1'b1, 5'd1, 32'h5);
`ifdef OPFETCH_BYPASS_EN
    check_eq("add_bypass_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
`else
    check_eq("add_nobypass_ready", {31'b0, bus.in_ready}, 32'h0);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    check_eq("add_wait_valid", {31'b0, bus.out_valid}, 32'h0);
    check_eq("add_wait_busy", bus.dbg_busy, 32'h0);
    check_eq("add_retry_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
`endif
    check_eq("add_out_valid", {31'b0, bus.out_valid}, 32'h1);
    check_eq("add_rs1", bus.out_rs1_val, 32'h5);
    check_eq("add_rs2", bus.out_rs2_val, 32'h5);
    check_eq("add_rd", {27'b0, bus.out_rd}, 32'h2);
    check_eq("add_imm", bus.out_imm, 32'h0);
    check_eq("add_busy", bus.dbg_busy, 32'h4);

    // Stall: out_ready low for 3 cycles with addi x3,x0,7 waiting.
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h00700193, 32'h108);
    held_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
      step();
      check_eq("stall_out_valid", {31'b0, bus.out_valid}, 32'h1);
      check_eq("stall_out_pc", bus.out_pc, held_pc);
      check_eq("stall_out_rd", {27'b0, bus.out_rd}, 32'h2);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check_eq("release_pc", bus.out_pc, 32'h108);
    check_eq("release_imm", bus.out_imm, 32'h7);
    check_eq("release_rd", {27'b0, bus.out_rd}, 32'h3);
    check_eq("release_busy", bus.dbg_busy, 32'hC);
    drive_in(1'b0, 32'h0, 32'h0);
    step();
    check_eq("no_dup_valid", {31'b0, bus.out_valid}, 32'h0);

    // Retire x2 and x3.
    drive_wb(1'b1, 5'd2, 32'h22);
    step();
    drive_wb(1'b1, 5'd3, 32'h33);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    check_eq("retire_busy", bus.dbg_busy, 32'h0);

    // beq x0,x0,-8
    drive_in(1'b1, 32'hFE000CE3, 32'h200);
    check_eq("beq_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check_eq("beq_imm", bus.out_imm, 32'hFFFFFFF8);
    check_eq("beq_busy", bus.dbg_busy, 32'h0);

    // jal x0,+2048
    drive_in(1'b1, 32'h0010006F, 32'h204);
    step();
    check_eq("jal_imm", bus.out_imm, 32'h00000800);
    check_eq("jal_rd", {27'b0, bus.out_rd}, 32'h0);
    check_eq("jal_busy", bus.dbg_busy, 32'h0);

    // Illegal opcode passes through.
    drive_in(1'b1, 32'h0000007F, 32'h208);
    check_eq("ill_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check_eq("ill_flag", {31'b0, bus.out_illegal}, 32'h1);
    check_eq("ill_imm", bus.out_imm, 32'h0);
    check_eq("ill_busy", bus.dbg_busy, 32'h0);

    // lw x3,4(x2) with x2 idle: no stall.
    drive_in(1'b1, 32'h00412183, 32'h20C);
    check_eq("lw_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check_eq("lw_pc", bus.out_pc, 32'h20C);
    check_eq("lw_rs1", bus.out_rs1_val, 32'h22);
    check_eq("lw_imm", bus.out_imm, 32'h4);
    check_eq("lw_illegal", {31'b0, bus.out_illegal}, 32'h0);
    check_eq("lw_funct3", {29'b0, bus.out_funct3}, 32'h2);
    check_eq("lw_busy", bus.dbg_busy, 32'h8);

    // addi x5,x0,1 accepted while x5 is written back: set wins.
    drive_in(1'b1, 32'h00100293, 32'h210);
    drive_wb(1'b1, 5'd5, 32'h0);
    check_eq("setwin_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    check_eq("setwin_busy", bus.dbg_busy, 32'h28);

    // Stall, then asynchronous reset mid-cycle.
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h00100313, 32'h214);
    step();
    check_eq("pre_rst_rd", {27'b0, bus.out_rd}, 32'h5);
    check_eq("pre_rst_valid", {31'b0, bus.out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
    check_eq("async_rst_busy", bus.dbg_busy, 32'h0);
    check_eq("async_rst_pc", bus.out_pc, 32'h0);
    check_eq("async_rst_imm", bus.out_imm, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
